// File: rtl/cn_u_minfind_if.sv
// Sample/result bundle between the v2c serialiser, the min-finder and its consumers.
// Latency: none (wires only).
// Backpressure: none; the producer presents one sample per cycle when valid.
interface cn_u_minfind_if #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7
);
  // v2c sample stream
  logic                   i_v2c_vld;
  logic [MSG_WIDTH-1:0]   i_v2c;
  logic [COL_CNT_WID-1:0] i_col_cnt;
  logic                   i_first;
  logic                   i_last;
  // compressed check-node row result
  logic [MSG_WIDTH-2:0]   o_v2c_abs_0;
  logic [MSG_WIDTH-2:0]   o_v2c_abs_1;
  logic [COL_CNT_WID-1:0] o_idx_0;
  logic                   o_v2c_sign_tot;
  logic                   o_vld;
  // per-edge sign write towards the sign memory
  logic                   o_v2c_sign;
  logic                   o_sign_vld;
  logic [COL_CNT_WID-1:0] o_sign_col;
  logic                   o_err;

  modport master (
    output i_v2c_vld, i_v2c, i_col_cnt, i_first, i_last,
    input  o_v2c_abs_0, o_v2c_abs_1, o_idx_0, o_v2c_sign_tot, o_vld,
    input  o_v2c_sign, o_sign_vld, o_sign_col, o_err
  );

  modport slave (
    input  i_v2c_vld, i_v2c, i_col_cnt, i_first, i_last,
    output o_v2c_abs_0, o_v2c_abs_1, o_idx_0, o_v2c_sign_tot, o_vld,
    output o_v2c_sign, o_sign_vld, o_sign_col, o_err
  );
endinterface

// File: rtl/cn_u_minfind.sv
// Check-node min-finder: folds a row of v2c messages into min0/min1/idx/sign-total.
// Latency: 1 cycle from an accepted sample to its sign strobe and, on i_last, to o_vld.
// Backpressure: none; accepts one sample every cycle, gaps allowed anywhere.
module cn_u_minfind #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cn_u_minfind_if.slave     bus
);

  localparam int MAG_W = MSG_WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [MAG_W-1:0]       min0_q, min0_d, min1_q, min1_d;
  logic [COL_CNT_WID-1:0] idx_q, idx_d;
  logic                   sgn_q, sgn_d;

  logic [MAG_W-1:0]       abs0_q, abs0_d, abs1_q, abs1_d;
  logic [COL_CNT_WID-1:0] idxo_q, idxo_d;
  logic                   tot_q, tot_d;
  logic                   vld_q, vld_d;
  logic                   sign_q, sign_d;
  logic                   sign_vld_q, sign_vld_d;
  logic [COL_CNT_WID-1:0] sign_col_q, sign_col_d;
  logic                   err_q, err_d;

  logic                   smp_s;
  logic [MSG_WIDTH-1:0]   smp_neg;
  logic [MAG_W-1:0]       smp_a;

  logic [MAG_W-1:0]       upd_min0, upd_min1;
  logic [COL_CNT_WID-1:0] upd_idx;
  logic                   upd_sgn;

  // Sign/magnitude split; -2^(W-1) has no positive twin so it saturates to all-ones.
  always_comb begin
    smp_s   = bus.i_v2c[MSG_WIDTH-1];
    smp_neg = -bus.i_v2c;
    smp_a   = bus.i_v2c[MAG_W-1:0];
    if (smp_s) begin
      smp_a = smp_neg[MSG_WIDTH-1] ? {MAG_W{1'b1}} : smp_neg[MAG_W-1:0];
    end
  end

  // Fold the current sample into the open row; strict compares keep the earliest column on ties.
  always_comb begin
    upd_min0 = min0_q;
    upd_min1 = min1_q;
    upd_idx  = idx_q;
    if (smp_a < min0_q) begin
      upd_min1 = min0_q;
      upd_min0 = smp_a;
      upd_idx  = bus.i_col_cnt;
    end else if (smp_a < min1_q) begin
      upd_min1 = smp_a;
    end
    upd_sgn = sgn_q ^ smp_s;
  end

  // Next-state and output decode: row open/close, result publish, sign strobe, error flag.
  always_comb begin
    state_d    = state_q;
    min0_d     = min0_q;
    min1_d     = min1_q;
    idx_d      = idx_q;
    sgn_d      = sgn_q;
    abs0_d     = abs0_q;
    abs1_d     = abs1_q;
    idxo_d     = idxo_q;
    tot_d      = tot_q;
    vld_d      = 1'b0;
    sign_d     = sign_q;
    sign_vld_d = 1'b0;
    sign_col_d = sign_col_q;
    err_d      = err_q;

    if (bus.i_v2c_vld) begin
      // Every accepted sample writes its sign, whether or not a row is open.
      sign_d     = smp_s;
      sign_col_d = bus.i_col_cnt;
      sign_vld_d = 1'b1;

      if (bus.i_first) begin
        // A new first column restarts the row; any partial row is dropped silently.
        min0_d = smp_a;
        min1_d = {MAG_W{1'b1}};
        idx_d  = bus.i_col_cnt;
        sgn_d  = smp_s;
        if (bus.i_last) begin
          abs0_d  = smp_a;
          abs1_d  = {MAG_W{1'b1}};
          idxo_d  = bus.i_col_cnt;
          tot_d   = smp_s;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACC;
        end
      end else if (state_q == ACC) begin
        min0_d = upd_min0;
        min1_d = upd_min1;
        idx_d  = upd_idx;
        sgn_d  = upd_sgn;
        if (bus.i_last) begin
          abs0_d  = upd_min0;
          abs1_d  = upd_min1;
          idxo_d  = upd_idx;
          tot_d   = upd_sgn;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end else begin
        // Mid-row sample with no open row: upstream lost sync.
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      min0_q     <= '0;
      min1_q     <= '0;
      idx_q      <= '0;
      sgn_q      <= 1'b0;
      abs0_q     <= '0;
      abs1_q     <= '0;
      idxo_q     <= '0;
      tot_q      <= 1'b0;
      vld_q      <= 1'b0;
      sign_q     <= 1'b0;
      sign_vld_q <= 1'b0;
      sign_col_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      min0_q     <= min0_d;
      min1_q     <= min1_d;
      idx_q      <= idx_d;
      sgn_q      <= sgn_d;
      abs0_q     <= abs0_d;
      abs1_q     <= abs1_d;
      idxo_q     <= idxo_d;
      tot_q      <= tot_d;
      vld_q      <= vld_d;
      sign_q     <= sign_d;
      sign_vld_q <= sign_vld_d;
      sign_col_q <= sign_col_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_v2c_abs_0    = abs0_q;
  assign bus.o_v2c_abs_1    = abs1_q;
  assign bus.o_idx_0        = idxo_q;
  assign bus.o_v2c_sign_tot = tot_q;
  assign bus.o_vld          = vld_q;
  assign bus.o_v2c_sign     = sign_q;
  assign bus.o_sign_vld     = sign_vld_q;
  assign bus.o_sign_col     = sign_col_q;
  assign bus.o_err          = err_q;

endmodule

// File: tb/tb_cn_u_minfind.sv
// Bench for the check-node min-finder: directed rows followed by random traffic.
// Latency: checks every output one cycle after each driven sample.
// Backpressure: none exercised; the DUT never stalls.
module tb_cn_u_minfind;

  logic i_clk;
  logic i_rst_n;

  cn_u_minfind_if #(.MSG_WIDTH(6), .COL_CNT_WID(7)) bus ();

  cn_u_minfind #(.MSG_WIDTH(6), .COL_CNT_WID(7)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the open row kept as plain lists of magnitudes/columns/signs.
  int q_mag[$];
  int q_col[$];
  int q_sgn[$];
  bit row_open;

  int exp_abs0, exp_abs1, exp_idx, exp_tot;
  int exp_vld, exp_sign, exp_sign_vld, exp_sign_col, exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vld"},  32'(bus.o_vld), 32'(exp_vld));
    chk({tag, ".abs0"}, 32'(bus.o_v2c_abs_0), 32'(exp_abs0));
    chk({tag, ".abs1"}, 32'(bus.o_v2c_abs_1), 32'(exp_abs1));
    chk({tag, ".idx0"}, 32'(bus.o_idx_0), 32'(exp_idx));
    chk({tag, ".tot"},  32'(bus.o_v2c_sign_tot), 32'(exp_tot));
    chk({tag, ".err"},  32'(bus.o_err), 32'(exp_err));
    chk({tag, ".svld"}, 32'(bus.o_sign_vld), 32'(exp_sign_vld));
    if (exp_sign_vld != 0) begin
      chk({tag, ".sign"}, 32'(bus.o_v2c_sign), 32'(exp_sign));
      chk({tag, ".scol"}, 32'(bus.o_sign_col), 32'(exp_sign_col));
    end
  endtask

  // Close the row: minimum with earliest column, second minimum over the remaining edges.
  task automatic publish();
    int pos, m1, t;
    pos = 0;
    for (int i = 1; i < q_mag.size(); i++)
      if (q_mag[i] < q_mag[pos]) pos = i;
    m1 = 31;
    t  = 0;
    for (int i = 0; i < q_mag.size(); i++) begin
      if (i != pos && q_mag[i] < m1) m1 = q_mag[i];
      t ^= q_sgn[i];
    end
    exp_abs0 = q_mag[pos];
    exp_idx  = q_col[pos];
    exp_abs1 = m1;
    exp_tot  = t;
    exp_vld  = 1;
  endtask

  task automatic drive(input string tag, input bit vld, input int val,
                       input int col, input bit first, input bit last);
    int mag, s;
    logic [5:0] raw;
    @(negedge i_clk);
    raw           = 6'(val);
    bus.i_v2c_vld = vld;
    bus.i_v2c     = raw;
    bus.i_col_cnt = 7'(col);
    bus.i_first   = first;
    bus.i_last    = last;
    exp_vld      = 0;
    exp_sign_vld = 0;
    if (vld) begin
      s   = (val < 0) ? 1 : 0;
      mag = (val < 0) ? -val : val;
      if (mag > 31) mag = 31;
      exp_sign     = s;
      exp_sign_col = col;
      exp_sign_vld = 1;
      if (first) begin
        q_mag.delete(); q_col.delete(); q_sgn.delete();
        row_open = 1;
      end
      if (row_open) begin
        q_mag.push_back(mag); q_col.push_back(col); q_sgn.push_back(s);
        if (last) begin
          publish();
          row_open = 0;
        end
      end else begin
        exp_err = 1;
      end
    end
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_rst_n       = 1'b0;
    bus.i_v2c_vld = 1'b1;
    bus.i_first   = 1'b0;
    bus.i_last    = 1'b1;
    bus.i_v2c     = 6'h21;
    bus.i_col_cnt = 7'd9;
    q_mag.delete(); q_col.delete(); q_sgn.delete();
    row_open = 0;
    exp_abs0 = 0; exp_abs1 = 0; exp_idx = 0; exp_tot = 0; exp_vld = 0;
    exp_sign = 0; exp_sign_vld = 0; exp_sign_col = 0; exp_err = 0;
    @(posedge i_clk);
    #1;
    chk({tag, ".sign"}, 32'(bus.o_v2c_sign), 32'd0);
    chk({tag, ".scol"}, 32'(bus.o_sign_col), 32'd0);
    check_all(tag);
    @(negedge i_clk);
    i_rst_n       = 1'b1;
    bus.i_v2c_vld = 1'b0;
  endtask

  initial begin
    int nvld, nfirst, nlast, rv, rc;
    i_rst_n       = 1'b0;
    bus.i_v2c_vld = 1'b0;
    bus.i_v2c     = '0;
    bus.i_col_cnt = '0;
    bus.i_first   = 1'b0;
    bus.i_last    = 1'b0;
    repeat (2) @(posedge i_clk);
    do_reset("reset");

    // Basic row: +5 -3 +7 -2 at columns 0..3.
    drive("r1c0", 1,  5, 0, 1, 0);
    drive("r1c1", 1, -3, 1, 0, 0);
    drive("r1c2", 1,  7, 2, 0, 0);
    drive("r1c3", 1, -2, 3, 0, 1);
    chk("r1_abs0", 32'(bus.o_v2c_abs_0), 32'd2);
    chk("r1_idx0", 32'(bus.o_idx_0), 32'd3);
    chk("r1_abs1", 32'(bus.o_v2c_abs_1), 32'd3);
    chk("r1_tot",  32'(bus.o_v2c_sign_tot), 32'd0);
    drive("r1idle", 0, 0, 0, 0, 0);

    // Ties with gaps inside the row.
    drive("r2c10", 1,  4, 10, 1, 0);
    drive("r2gap", 0, 31, 99, 1, 1);
    drive("r2c11", 1, -4, 11, 0, 0);
    drive("r2gap", 0, -7, 5, 0, 1);
    drive("r2gap", 0,  0, 0, 0, 0);
    drive("r2c12", 1, -6, 12, 0, 1);
    chk("r2_abs0", 32'(bus.o_v2c_abs_0), 32'd4);
    chk("r2_idx0", 32'(bus.o_idx_0), 32'd10);
    chk("r2_abs1", 32'(bus.o_v2c_abs_1), 32'd4);

    // Single-column row at the most negative value.
    drive("r3c5", 1, -32, 5, 1, 1);
    chk("r3_abs0", 32'(bus.o_v2c_abs_0), 32'd31);
    chk("r3_abs1", 32'(bus.o_v2c_abs_1), 32'd31);
    chk("r3_tot",  32'(bus.o_v2c_sign_tot), 32'd1);

    // Restart: the first partial row is abandoned.
    drive("r4c0", 1, 1, 0, 1, 0);
    drive("r4c1", 1, 2, 1, 0, 0);
    drive("r4c0b", 1, 9, 0, 1, 0);
    drive("r4c1b", 1, -8, 1, 0, 1);
    chk("r4_abs0", 32'(bus.o_v2c_abs_0), 32'd8);
    chk("r4_idx0", 32'(bus.o_idx_0), 32'd1);
    chk("r4_abs1", 32'(bus.o_v2c_abs_1), 32'd9);
    chk("r4_tot",  32'(bus.o_v2c_sign_tot), 32'd1);

    // Reset mid-row, then a stray last sample.
    drive("r5c0", 1, 3, 0, 1, 0);
    do_reset("r5rst");
    drive("r5last", 1, -1, 1, 0, 1);
    chk("r5_err", 32'(bus.o_err), 32'd1);
    drive("r5hold", 0, 0, 0, 0, 0);
    drive("r5row", 1, 6, 2, 1, 1);

    // Back-to-back rows with no bubble.
    drive("r6a0", 1, -10, 20, 1, 0);
    drive("r6a1", 1,  12, 21, 0, 1);
    drive("r6b0", 1,   1, 30, 1, 0);
    chk("r6_hold_abs0", 32'(bus.o_v2c_abs_0), 32'd10);
    drive("r6b1", 1,  -2, 31, 0, 0);
    drive("r6b2", 1,  15, 32, 0, 1);
    chk("r6_abs0", 32'(bus.o_v2c_abs_0), 32'd1);
    chk("r6_idx0", 32'(bus.o_idx_0), 32'd30);

    // Random traffic: valid gaps, restarts, stray samples, occasional resets.
    do_reset("rndrst");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rndrst");
      end else begin
        nvld   = ($urandom_range(0, 3) != 0) ? 1 : 0;
        nfirst = ($urandom_range(0, 5) == 0) ? 1 : 0;
        nlast  = ($urandom_range(0, 4) == 0) ? 1 : 0;
        rv     = $urandom_range(0, 63) - 32;
        rc     = $urandom_range(0, 127);
        drive("rnd", nvld[0], rv, rc, nfirst[0], nlast[0]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
